// File: rtl/seg7_scan_decoder_pkg.sv
// Shared glyph table and per-digit state type for the 7-segment scan decoder.
// Glyph constants are lit-segment patterns (g..a, 1 = lit).
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;  // raw active-low bus with every segment dark

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [15:0][6:0] GLYPH_LIT = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return GLYPH_LIT[nib];
  endfunction

  typedef struct packed {
    logic [3:0] nibble;
    logic       dot;
    logic       blank;
    logic       invalid;
  } digit_state_t;

  localparam digit_state_t DIGIT_RESET = '{nibble: 4'h0, dot: 1'b0, blank: 1'b1, invalid: 1'b0};

endpackage

// File: rtl/seg7_scan_decoder_glyph_lookup.sv
// Combinational reverse lookup: raw active-low segment pattern -> hex nibble.
// Blank and non-glyph patterns are flagged; nibble is 0 when no glyph matches.
module seg7_glyph_lookup
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_is_glyph,
  output logic       o_is_blank
);

  logic [6:0] w_lit;

  assign w_lit      = ~i_pattern;
  assign o_is_blank = (i_pattern == SEG_BLANK);

  always_comb begin
    o_nibble   = 4'h0;
    o_is_glyph = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (w_lit == seg_encode(4'(n))) begin
        o_nibble   = 4'(n);
        o_is_glyph = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a scanned 7-segment display: synchronise, debounce each scan
// slot, decode the stable glyph and hold one decoded result per digit.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int IDX_W         = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            segments,
  input  logic [DIGITS-1:0]     anodes,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     dots,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     invalid,
  output logic                  update,
  output logic [IDX_W-1:0]      update_index
);

  localparam int SW = DIGITS + 8;

  logic [SW-1:0]        r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0]     r_cnt;
  digit_state_t         r_state [DIGITS];
  logic                 r_update;
  logic [IDX_W-1:0]     r_update_idx;

  logic [DIGITS-1:0]    w_sel;
  logic                 w_onehot;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_commit;
  logic [7:0]           w_seg_s;
  logic [3:0]           w_nibble;
  logic                 w_is_glyph, w_is_blank;
  digit_state_t         w_cur, w_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {anodes, segments};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev)
        r_cnt <= '0;
      else if (r_cnt != CNT_W'(STABLE_CYCLES))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_seg_s  = r_sync2[7:0];
  assign w_sel    = ~r_sync2[SW-1:8];
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (w_sel[i]) w_idx = IDX_W'(i);
  end

  // Fires once per held pattern, on the step into saturation; ghosts are dropped.
  assign w_commit = (r_sync2 == r_prev) && (r_cnt == CNT_W'(STABLE_CYCLES - 1)) && w_onehot;

  seg7_glyph_lookup u_lookup (
    .i_pattern  (w_seg_s[6:0]),
    .o_nibble   (w_nibble),
    .o_is_glyph (w_is_glyph),
    .o_is_blank (w_is_blank)
  );

  assign w_cur = r_state[w_idx];

  always_comb begin
    w_next         = w_cur;
    w_next.dot     = ~w_seg_s[7];
    w_next.blank   = w_is_blank;
    w_next.invalid = ~w_is_glyph & ~w_is_blank;
    if (w_is_glyph) w_next.nibble = w_nibble;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIGITS; i++) r_state[i] <= DIGIT_RESET;
      r_update     <= 1'b0;
      r_update_idx <= '0;
    end else begin
      r_update <= w_commit && (w_next != w_cur);
      if (w_commit) begin
        r_state[w_idx] <= w_next;
        r_update_idx   <= w_idx;
      end
    end
  end

  always_comb begin
    digits  = '0;
    dots    = '0;
    blank   = '0;
    invalid = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digits[4*i +: 4] = r_state[i].nibble;
      dots[i]          = r_state[i].dot;
      blank[i]         = r_state[i].blank;
      invalid[i]       = r_state[i].invalid;
    end
  end

  assign update       = r_update;
  assign update_index = r_update_idx;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios with literal expectations plus
// randomized scan slots checked every cycle against a sample-history model.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int IDX_W  = 2;
  localparam int SC     = 8;
  localparam int CNT_W  = 4;

  localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  segments;
  logic [3:0]  anodes;
  logic [15:0] digits;
  logic [3:0]  dots, blank, invalid;
  logic        update;
  logic [1:0]  update_index;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;
  logic [1:0] last_idx = 2'd0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(DIGITS), .IDX_W(IDX_W), .STABLE_CYCLES(SC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .segments     (segments),
    .anodes       (anodes),
    .digits       (digits),
    .dots         (dots),
    .blank        (blank),
    .invalid      (invalid),
    .update       (update),
    .update_index (update_index)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a slot commits at edge n when the pins sampled at edges n-SC-2..n-2
  // all agree and the sample at edge n-SC-3 differs (reset history reads as 0).
  logic [11:0] q[$];
  logic [3:0]  m_nib [4];
  logic [3:0]  m_dot, m_blank, m_inv;
  logic        m_upd;
  logic [1:0]  m_idx;
  logic [11:0] mp;
  logic [6:0]  mlit;
  logic [3:0]  nn;
  logic        nb, ni, nd;
  bit          mstable;
  int          mlow, mhot;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      for (int k = 0; k < SC + 3; k++) q.push_back(12'h000);
      for (int k = 0; k < 4; k++) m_nib[k] <= 4'h0;
      m_dot   <= 4'h0;
      m_blank <= 4'hF;
      m_inv   <= 4'h0;
      m_upd   <= 1'b0;
      m_idx   <= 2'd0;
    end else begin
      mp      = q[1];
      mstable = (q[0] != mp);
      for (int k = 2; k <= SC + 1; k++) if (q[k] != mp) mstable = 1'b0;
      mlow = 0;
      mhot = 0;
      for (int k = 0; k < 4; k++) if (!mp[8+k]) begin mlow++; mhot = k; end
      m_upd <= 1'b0;
      if (mstable && mlow == 1) begin
        mlit = ~mp[6:0];
        nd   = ~mp[7];
        nb   = (mp[6:0] == 7'h7F);
        nn   = m_nib[mhot];
        ni   = !nb;
        for (int g = 0; g < 16; g++) if (mlit == LIT[g]) begin nn = 4'(g); ni = 1'b0; end
        if (nn != m_nib[mhot] || nd != m_dot[mhot] || nb != m_blank[mhot] || ni != m_inv[mhot]) begin
          m_upd <= 1'b1;
          m_idx <= 2'(mhot);
        end
        m_nib[mhot]   <= nn;
        m_dot[mhot]   <= nd;
        m_blank[mhot] <= nb;
        m_inv[mhot]   <= ni;
      end
      q.push_back({anodes, segments});
      void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_digits",  digits,  {m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
      check("m_dots",    dots,    m_dot);
      check("m_blank",   blank,   m_blank);
      check("m_invalid", invalid, m_inv);
      check("m_update",  update,  m_upd);
      if (m_upd) check("m_upd_index", update_index, m_idx);
    end
  end

  always @(negedge clk) begin
    if (update) begin
      pulses   <= pulses + 1;
      last_idx <= update_index;
    end
  end

  // Called just after a falling edge; returns just after a falling edge.
  task automatic hold(input logic [3:0] an, input logic [7:0] sg, input int n);
    anodes   = an;
    segments = sg;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_digits"},  digits,  16'h0000);
    check({tag, "_dots"},    dots,    4'h0);
    check({tag, "_blank"},   blank,   4'hF);
    check({tag, "_invalid"}, invalid, 4'h0);
    check({tag, "_update"},  update,  1'b0);
    check({tag, "_uidx"},    update_index, 2'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int p0;
  logic [3:0] an;
  logic [6:0] sg7;
  int r;

  initial begin
    reset_n  = 1'b0;
    anodes   = 4'hF;
    segments = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;
    chk_en  = 1'b1;
    hold(4'hF, 8'hFF, 4);

    // digit 0 shows '0', pulse exactly at the 11th sampling edge
    p0 = pulses;
    anodes   = 4'b1110;
    segments = 8'hC0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (e == 10) check("s1_no_early_upd", update, 1'b0);
      if (e == 11) begin
        check("s1_upd_edge11", update, 1'b1);
        check("s1_upd_idx", update_index, 2'd0);
      end
    end
    @(negedge clk);
    #1;
    check("s1_digit0", digits[3:0], 4'h0);
    check("s1_blank0", blank[0], 1'b0);
    check("s1_dot0",   dots[0],  1'b0);
    check("s1_pulses", pulses - p0, 1);

    p0 = pulses;
    hold(4'b0111, 8'h08, 12);
    check("s2_digit3", digits[15:12], 4'hA);
    check("s2_dot3",   dots[3], 1'b1);
    check("s2_pulses", pulses - p0, 1);
    check("s2_idx",    last_idx, 2'd3);
    p0 = pulses;
    hold(4'b0111, 8'h08, 50);
    check("s2_held_no_pulse", pulses - p0, 0);

    p0 = pulses;
    hold(4'b1101, 8'hF9, 6);
    hold(4'b1101, 8'hA4, 12);
    check("s3_digit1", digits[7:4], 4'h2);
    check("s3_pulses", pulses - p0, 1);

    p0 = pulses;
    hold(4'b1100, 8'hC0, 20);
    check("s4_pulses", pulses - p0, 0);
    check("s4_digits", digits, 16'hA020);
    check("s4_blank",  blank,  4'b0100);
    check("s4_dots",   dots,   4'b1000);

    hold(4'b1011, 8'hFE, 12);
    check("s5_invalid2", invalid[2], 1'b1);
    check("s5_digit2",   digits[11:8], 4'h0);
    check("s5_blank2",   blank[2], 1'b0);
    hold(4'b1011, 8'hFF, 12);
    check("s5_blank2_b",   blank[2], 1'b1);
    check("s5_invalid2_b", invalid[2], 1'b0);

    // reset while cnt is 5 on a fresh pattern
    anodes   = 4'b1110;
    segments = 8'h92;
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    p0 = pulses;
    hold(4'b1110, 8'h92, 12);
    check("rst_recommit_digit0", digits[3:0], 4'h5);
    check("rst_recommit_blank0", blank[0], 1'b0);
    check("rst_recommit_pulses", pulses - p0, 1);

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7) an = ~(4'b0001 << $urandom_range(0, 3));
      else       an = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)      sg7 = ~LIT[$urandom_range(0, 15)];
      else if (r < 7) sg7 = 7'h7F;
      else            sg7 = 7'($urandom);
      hold(an, {1'($urandom), sg7}, $urandom_range(1, 20));
      if (k == 200) begin
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_vals("rnd_rst");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
